// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared types and sizing for the result-word UART streamer
package stream_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int DEF_DATA_W     = 40;
    localparam int BYTES_PER_WORD = DEF_DATA_W / 8;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    // A write into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/data_uart_streamer.sv
// rtl/data_uart_streamer.sv - captures processor result words and sends them MSB byte first over UART 8N1
module data_uart_streamer
    import stream_pkg::*;
#(
    parameter int DATA_W       = 40,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_W-1:0]              data,
    input  logic                           enable,
    output logic                           tx,
    output logic                           busy,
    output logic                           overflow,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

    localparam int NBYTES = bytes_per_word(DATA_W);
    localparam int BW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int YW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    tx_state_t         state_q, state_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [YW-1:0]     byte_idx_q, byte_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              overflow_q;
    logic [7:0]        cur_byte_d;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop, bit_end;
    logic [DATA_W-1:0] fifo_dout;

    assign fifo_pop  = (state_q == IDLE) & ~fifo_empty;
    assign fifo_push = enable & (~fifo_full | fifo_pop);
    assign bit_end   = (baud_q == BW'(CLKS_PER_BIT - 1));

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + BW'(1);
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    shift_d    = fifo_dout;
                    byte_idx_d = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (byte_idx_q != YW'(NBYTES - 1)) begin
                        byte_idx_d = byte_idx_q + YW'(1);
                        shift_d    = shift_q << 8;
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is registered from next-state values so the line changes together with the state.
        cur_byte_d = shift_d[DATA_W-1 -: 8];
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte_d[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_q | (enable & fifo_full & ~fifo_pop);
        end
    end

    assign tx       = tx_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) | (fifo_count != '0);

endmodule

// File: tb/tb_data_uart_streamer.sv
// tb/tb_data_uart_streamer.sv - directed self-checking bench for data_uart_streamer
module tb_data_uart_streamer;

    localparam int DATA_W = 40;
    localparam int DEPTH  = 8;
    localparam int CPB    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] data;
    logic              enable;
    logic              tx, busy, overflow;
    logic [3:0]        fifo_count;

    int   vectors     = 0;
    int   miscompares = 0;
    logic mon_en;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    data_uart_streamer #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .enable     (enable),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] w);
        for (int i = DATA_W/8 - 1; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w, input bit expect_tx);
        data   = w;
        enable = 1'b1;
        if (expect_tx) push_exp(w);
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_vec(tag, busy, 0);
    endtask

    task automatic compare_rx(input string tag);
        int n;
        check_vec({tag, "_nbytes"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_vec($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    // UART receiver: samples each bit in the middle of its CPB-cycle window.
    initial begin
        logic [7:0] b;
        logic       sb;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (CPB/2) @(negedge clk);
                sb = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (mon_en) begin
                    check_vec("rx_start_bit", sb, 0);
                    check_vec("rx_stop_bit", tx, 1);
                    rx_q.push_back(b);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] w;
        rst    = 1'b1;
        enable = 1'b0;
        data   = '0;
        mon_en = 1'b1;

        // Reset idle
        wait_neg(3);
        check_vec("rst_tx", tx, 1);
        check_vec("rst_busy", busy, 0);
        check_vec("rst_overflow", overflow, 0);
        check_vec("rst_count", fifo_count, 0);
        rst = 1'b0;
        wait_neg(2);

        // Single word: latency, frame length, byte order
        send_word(40'h123456789A, 1);
        wait_neg(1);
        enable = 1'b0;
        check_vec("t2_tx_n1", tx, 1);
        check_vec("t2_count_n1", fifo_count, 1);
        wait_neg(1);
        check_vec("t2_tx_start_n2", tx, 0);
        check_vec("t2_busy_n2", busy, 1);
        check_vec("t2_count_n2", fifo_count, 0);
        wait_neg(199);
        check_vec("t2_busy_last", busy, 1);
        check_vec("t2_tx_last", tx, 1);
        wait_neg(1);
        check_vec("t2_busy_done", busy, 0);
        wait_neg(5);
        compare_rx("t2");

        // Two words: exactly one idle cycle between them
        send_word(40'hA1B2C3D4E5, 1);
        wait_neg(1);
        send_word(40'h0F1E2D3C4B, 1);
        wait_neg(1);
        enable = 1'b0;
        check_vec("t6_tx_start", tx, 0);
        wait_neg(199);
        check_vec("t6_tx_stop", tx, 1);
        wait_neg(1);
        check_vec("t6_tx_gap", tx, 1);
        check_vec("t6_busy_gap", busy, 1);
        wait_neg(1);
        check_vec("t6_tx_start2", tx, 0);
        wait_idle("t6_drain");
        wait_neg(5);
        compare_rx("t6");

        // Ten back-to-back words: tenth dropped, overflow sticky
        for (int k = 0; k < 10; k++) begin
            w = {8'(k), 8'hA5, 8'(k * 3), 8'h5A, 8'(255 - k)};
            send_word(w, k < 9);
            wait_neg(1);
        end
        enable = 1'b0;
        check_vec("t3_count_full", fifo_count, 8);
        check_vec("t3_overflow", overflow, 1);
        wait_idle("t3_drain");
        check_vec("t3_overflow_held", overflow, 1);
        check_vec("t3_count_empty", fifo_count, 0);
        wait_neg(5);
        compare_rx("t3");

        // Full FIFO, push on the pop cycle
        rst = 1'b1;
        wait_neg(1);
        check_vec("t4_rst_overflow", overflow, 0);
        rst = 1'b0;
        wait_neg(1);
        for (int k = 0; k < 9; k++) begin
            w = {8'h30 + 8'(k), 8'hC0, 8'(k * 7), 8'h0F, 8'hE0 + 8'(k)};
            send_word(w, 1);
            wait_neg(1);
        end
        enable = 1'b0;
        check_vec("t4_count_c9", fifo_count, 8);
        wait_neg(192);
        check_vec("t4_count_c201", fifo_count, 8);
        check_vec("t4_busy_c201", busy, 1);
        wait_neg(1);
        check_vec("t4_tx_idle_c202", tx, 1);
        send_word(40'hDEADBEEF01, 1);
        wait_neg(1);
        enable = 1'b0;
        check_vec("t4_count_after", fifo_count, 8);
        check_vec("t4_overflow", overflow, 0);
        check_vec("t4_tx_start", tx, 0);
        wait_idle("t4_drain");
        wait_neg(5);
        compare_rx("t4");

        // Reset in the middle of the third byte's data bits
        send_word(40'h1111111111, 1);
        wait_neg(1);
        send_word(40'h2222222222, 1);
        wait_neg(1);
        enable = 1'b0;
        wait_neg(93);
        mon_en = 1'b0;
        rst    = 1'b1;
        wait_neg(1);
        check_vec("t5_tx_rst", tx, 1);
        check_vec("t5_count_rst", fifo_count, 0);
        check_vec("t5_busy_rst", busy, 0);
        rst = 1'b0;
        wait_neg(60);
        rx_q.delete();
        exp_q.delete();
        mon_en = 1'b1;
        send_word(40'h5AC3E7183C, 1);
        wait_neg(1);
        enable = 1'b0;
        wait_idle("t5_drain");
        wait_neg(5);
        compare_rx("t5");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
